// File: rtl/arilla_sba_pkg.sv
// Shared types and helpers for the System Bus Access initiator.
// Holds the size, error and state encodings plus the command legality check.
package arilla_sba_pkg;

    localparam logic [1:0] ERR_CODE_OK         = 2'd0;
    localparam logic [1:0] ERR_CODE_TIMEOUT    = 2'd1;
    localparam logic [1:0] ERR_CODE_MISALIGNED = 2'd2;
    localparam logic [1:0] ERR_CODE_BAD_SIZE   = 2'd3;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } sba_size_t;

    typedef enum logic [1:0] {
        ERR_OK         = ERR_CODE_OK,
        ERR_TIMEOUT    = ERR_CODE_TIMEOUT,
        ERR_MISALIGNED = ERR_CODE_MISALIGNED,
        ERR_BAD_SIZE   = ERR_CODE_BAD_SIZE
    } sba_error_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRAB   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } sba_state_t;

    typedef struct packed {
        logic        write;
        sba_size_t   size;
        logic [31:0] address;
        logic [31:0] wdata;
    } sba_cmd_t;

    // Commands rejected here never touch the bus.
    function automatic sba_error_t check_cmd(input sba_size_t size, input logic [1:0] offset);
        sba_error_t err;
        err = ERR_OK;
        case (size)
            SIZE_RSVD: err = ERR_BAD_SIZE;
            SIZE_HALF: if (offset[0])         err = ERR_MISALIGNED;
            SIZE_WORD: if (offset != 2'b00)   err = ERR_MISALIGNED;
            default:   err = ERR_OK;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/arilla_bus_if.sv
// Arilla bus connection between an initiator (master) and the fabric/memory (slave).
interface arilla_bus_if;
    logic [31:0] address;
    logic [31:0] data_write;
    logic [31:0] data_read;
    logic [3:0]  byte_enable;
    logic        read;
    logic        write;
    logic        intercept;
    logic        available;

    modport master (
        output address, data_write, byte_enable, read, write, intercept,
        input  data_read, available
    );

    modport slave (
        input  address, data_write, byte_enable, read, write, intercept,
        output data_read, available
    );
endinterface

// File: rtl/sba_lane_align.sv
// Combinational lane steering: byte enables, write-data replication and
// right-aligned, zero-extended read-data extraction from size and byte offset.
module sba_lane_align
    import arilla_sba_pkg::*;
(
    input  sba_size_t   size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  byte_enable,
    output logic [31:0] bus_wdata,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = bus_rdata >> {offset, 3'b000};

    always_comb begin
        byte_enable = 4'b0000;
        bus_wdata   = 32'h0;
        rdata       = 32'h0;
        case (size)
            SIZE_BYTE: begin
                byte_enable = 4'b0001 << offset;
                bus_wdata   = {4{wdata[7:0]}};
                rdata       = {24'h0, shifted[7:0]};
            end
            SIZE_HALF: begin
                byte_enable = 4'b0011 << offset;
                bus_wdata   = {2{wdata[15:0]}};
                rdata       = {16'h0, shifted[15:0]};
            end
            SIZE_WORD: begin
                byte_enable = 4'b1111;
                bus_wdata   = wdata;
                rdata       = bus_rdata;
            end
            default: begin
                byte_enable = 4'b0000;
                bus_wdata   = 32'h0;
                rdata       = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/sba_initiator.sv
// System Bus Access initiator: grabs the arilla bus from the core, runs one
// access and returns an aligned result. `SBA_TIMEOUT_EN adds an access timeout.
module sba_initiator
    import arilla_sba_pkg::*;
#(
    parameter int GuardCycles   = 1,
    parameter int TimeoutCycles = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_write,
    input  logic [1:0]   cmd_size,
    input  logic [31:0]  cmd_address,
    input  logic [31:0]  cmd_wdata,
    output logic         rsp_valid,
    output logic [31:0]  rsp_rdata,
    output logic [1:0]   rsp_error,
    output logic         busy,
    arilla_bus_if.master bus_interface
);

`ifdef SBA_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    // One counter serves the guard phase and, when enabled, the access timeout.
    localparam int CntMax = (TimeoutEn && (TimeoutCycles > GuardCycles)) ? TimeoutCycles : GuardCycles;
    localparam int CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);
    localparam logic [CntW-1:0] GuardLast = CntW'(GuardCycles - 1);
`ifdef SBA_TIMEOUT_EN
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
`endif

    sba_state_t      state;
    sba_state_t      state_next;
    sba_cmd_t        cmd_q;
    logic [CntW-1:0] cnt;
    sba_error_t      cmd_err;
    logic            drive_bus;

    logic [3:0]      lane_be;
    logic [31:0]     lane_wdata;
    logic [31:0]     lane_rdata;

    assign cmd_err = check_cmd(sba_size_t'(cmd_size), cmd_address[1:0]);

    sba_lane_align u_lane_align (
        .size        (cmd_q.size),
        .offset      (cmd_q.address[1:0]),
        .wdata       (cmd_q.wdata),
        .bus_rdata   (bus_interface.data_read),
        .byte_enable (lane_be),
        .bus_wdata   (lane_wdata),
        .rdata       (lane_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_err == ERR_OK) ? ST_GRAB : ST_RESP;
                end
            end
            ST_GRAB: begin
                if (cnt == GuardLast) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (bus_interface.available) begin
                    state_next = ST_RESP;
                end
`ifdef SBA_TIMEOUT_EN
                else if (cnt == TimeoutLast) begin
                    state_next = ST_RESP;
                end
`endif
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Command latch, phase counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q     <= '0;
            cnt       <= '0;
            rsp_rdata <= 32'h0;
            rsp_error <= ERR_CODE_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q <= '{write: cmd_write, size: sba_size_t'(cmd_size),
                                   address: cmd_address, wdata: cmd_wdata};
                        cnt   <= '0;
                        if (cmd_err != ERR_OK) begin
                            rsp_error <= cmd_err;
                        end
                    end
                end
                ST_GRAB: begin
                    cnt <= (cnt == GuardLast) ? '0 : cnt + 1'b1;
                end
                ST_ACCESS: begin
                    if (bus_interface.available) begin
                        rsp_error <= ERR_CODE_OK;
                        if (!cmd_q.write) begin
                            rsp_rdata <= lane_rdata;
                        end
                    end
`ifdef SBA_TIMEOUT_EN
                    else if (cnt == TimeoutLast) begin
                        rsp_error <= ERR_CODE_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Bus controls decode straight from state so reset drops them immediately.
    always_comb begin
        cmd_ready                 = (state == ST_IDLE);
        busy                      = (state != ST_IDLE);
        rsp_valid                 = (state == ST_RESP);
        drive_bus                 = (state == ST_GRAB) || (state == ST_ACCESS);
        bus_interface.intercept   = drive_bus;
        bus_interface.read        = (state == ST_ACCESS) && !cmd_q.write;
        bus_interface.write       = (state == ST_ACCESS) &&  cmd_q.write;
        bus_interface.address     = drive_bus ? {cmd_q.address[31:2], 2'b00} : 32'h0;
        bus_interface.data_write  = drive_bus ? lane_wdata : 32'h0;
        bus_interface.byte_enable = drive_bus ? lane_be : 4'b0000;
    end

endmodule

// File: tb/tb_sba_initiator.sv
// Directed bench for sba_initiator with a small byte-enabled memory responder.
module tb_sba_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic [31:0] cmd_address;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_error;
    logic        busy;
    logic        hold_avail;

    int vectors     = 0;
    int miscompares = 0;

    arilla_bus_if bus();

    sba_initiator #(.GuardCycles(1), .TimeoutCycles(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_size      (cmd_size),
        .cmd_address   (cmd_address),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_error     (rsp_error),
        .busy          (busy),
        .bus_interface (bus)
    );

    always #5 clk = ~clk;

    // Memory responder: answers in the first strobe cycle unless held off.
    logic [31:0] mem [0:63];
    assign bus.available = (bus.read | bus.write) & ~hold_avail;
    assign bus.data_read = mem[bus.address[7:2]];

    always @(posedge clk) begin
        if (bus.write && bus.available) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byte_enable[b]) mem[bus.address[7:2]][8*b +: 8] <= bus.data_write[8*b +: 8];
            end
        end
    end

    int          strobe_cnt  = 0;
    int          icpt_cnt    = 0;
    int          rspv_cnt    = 0;
    int          overlap_cnt = 0;
    logic [3:0]  last_be     = 4'h0;
    logic [31:0] last_wd     = 32'h0;
    logic [31:0] last_addr   = 32'h0;

    always @(posedge clk) begin
        if (bus.read || bus.write) begin
            strobe_cnt <= strobe_cnt + 1;
            last_be    <= bus.byte_enable;
            last_wd    <= bus.data_write;
            last_addr  <= bus.address;
        end
        if (bus.intercept)       icpt_cnt    <= icpt_cnt + 1;
        if (rsp_valid)           rspv_cnt    <= rspv_cnt + 1;
        if (busy && cmd_ready)   overlap_cnt <= overlap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one command once the initiator is idle; lat counts cycles after accept.
    task automatic run_cmd(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input int budget, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_write   = w;
        cmd_size    = sz;
        cmd_address = a;
        cmd_wdata   = d;
        cmd_valid   = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < budget) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int s0;
        int i0;
        int r0;
        int rsp_it;
        int acc_it;
        int n;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_size    = 2'd0;
        cmd_address = 32'h0;
        cmd_wdata   = 32'h0;
        hold_avail  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_intercept", bus.intercept, 0);
        chk("rst_read", bus.read, 0);
        chk("rst_write", bus.write, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_address", bus.address, 0);
        chk("rst_data_write", bus.data_write, 0);
        chk("rst_byte_enable", bus.byte_enable, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word write, cycle by cycle.
        @(negedge clk);
        cmd_write = 1'b1; cmd_size = 2'd2; cmd_address = 32'h100; cmd_wdata = 32'hDEADBEEF;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("ww_c1_intercept", bus.intercept, 1);
        chk("ww_c1_write", bus.write, 0);
        chk("ww_c1_busy", busy, 1);
        chk("ww_c1_ready", cmd_ready, 0);
        @(posedge clk); #1;
        chk("ww_c2_write", bus.write, 1);
        chk("ww_c2_be", bus.byte_enable, 4'b1111);
        chk("ww_c2_addr", bus.address, 32'h100);
        chk("ww_c2_wdata", bus.data_write, 32'hDEADBEEF);
        chk("ww_c2_intercept", bus.intercept, 1);
        @(posedge clk); #1;
        chk("ww_c3_rsp_valid", rsp_valid, 1);
        chk("ww_c3_rsp_error", rsp_error, 0);
        chk("ww_c3_intercept", bus.intercept, 0);
        chk("ww_c3_write", bus.write, 0);
        @(posedge clk); #1;
        chk("ww_c4_rsp_valid", rsp_valid, 0);
        chk("ww_c4_ready", cmd_ready, 1);

        run_cmd(1'b0, 2'd2, 32'h100, 32'h0, 20, lat);
        chk("wr_lat", lat, 3);
        chk("wr_err", rsp_error, 0);
        chk("wr_rdata", rsp_rdata, 32'hDEADBEEF);

        run_cmd(1'b1, 2'd2, 32'h100, 32'h11223344, 20, lat);
        chk("w2_lat", lat, 3);
        chk("w2_rdata_held", rsp_rdata, 32'hDEADBEEF);

        run_cmd(1'b0, 2'd0, 32'h103, 32'h0, 20, lat);
        chk("br3_rdata", rsp_rdata, 32'h00000011);
        chk("br3_be", last_be, 4'b1000);
        chk("br3_addr", last_addr, 32'h100);
        run_cmd(1'b0, 2'd0, 32'h101, 32'h0, 20, lat);
        chk("br1_rdata", rsp_rdata, 32'h00000033);
        chk("br1_be", last_be, 4'b0010);
        run_cmd(1'b0, 2'd1, 32'h102, 32'h0, 20, lat);
        chk("hr2_rdata", rsp_rdata, 32'h00001122);
        chk("hr2_be", last_be, 4'b1100);
        run_cmd(1'b0, 2'd1, 32'h100, 32'h0, 20, lat);
        chk("hr0_rdata", rsp_rdata, 32'h00003344);
        chk("hr0_be", last_be, 4'b0011);

        run_cmd(1'b1, 2'd0, 32'h102, 32'h000000AB, 20, lat);
        chk("bw_wdata", last_wd, 32'hABABABAB);
        chk("bw_be", last_be, 4'b0100);
        run_cmd(1'b1, 2'd1, 32'h100, 32'h0000CAFE, 20, lat);
        chk("hw_wdata", last_wd, 32'hCAFECAFE);
        chk("hw_be", last_be, 4'b0011);
        run_cmd(1'b0, 2'd2, 32'h100, 32'h0, 20, lat);
        chk("merge_rdata", rsp_rdata, 32'h11ABCAFE);
        run_cmd(1'b1, 2'd2, 32'h104, 32'h0BADF00D, 20, lat);
        chk("w104_err", rsp_error, 0);

        // Rejected commands never reach the bus.
        s0 = strobe_cnt;
        i0 = icpt_cnt;
        run_cmd(1'b0, 2'd1, 32'h101, 32'h0, 20, lat);
        chk("mis_half_lat", lat, 1);
        chk("mis_half_err", rsp_error, 2);
        chk("mis_half_rdata", rsp_rdata, 32'h11ABCAFE);
        run_cmd(1'b0, 2'd2, 32'h102, 32'h0, 20, lat);
        chk("mis_word_err", rsp_error, 2);
        run_cmd(1'b1, 2'd3, 32'h100, 32'h0, 20, lat);
        chk("bad_size_lat", lat, 1);
        chk("bad_size_err", rsp_error, 3);
        @(posedge clk); #1;
        chk("err_no_strobe", strobe_cnt, s0);
        chk("err_no_intercept", icpt_cnt, i0);

        // Responder holds available low.
        hold_avail = 1'b1;
        s0 = strobe_cnt;
`ifdef SBA_TIMEOUT_EN
        run_cmd(1'b0, 2'd2, 32'h104, 32'h0, 40, lat);
        chk("tmo_lat", lat, 18);
        chk("tmo_err", rsp_error, 1);
        chk("tmo_rdata", rsp_rdata, 32'h11ABCAFE);
        chk("tmo_intercept", bus.intercept, 0);
        chk("tmo_access_cycles", strobe_cnt - s0, 16);
        hold_avail = 1'b0;
`else
        run_cmd(1'b0, 2'd2, 32'h104, 32'h0, 1000, lat);
        chk("hold_no_rsp", rsp_valid, 0);
        chk("hold_busy", busy, 1);
        chk("hold_read", bus.read, 1);
        chk("hold_intercept", bus.intercept, 1);
        hold_avail = 1'b0;
        @(posedge clk); #1;
        chk("hold_rsp_valid", rsp_valid, 1);
        chk("hold_err", rsp_error, 0);
        chk("hold_rdata", rsp_rdata, 32'h0BADF00D);
`endif

        // Reset during ACCESS.
        hold_avail = 1'b1;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_write = 1'b0; cmd_size = 2'd2; cmd_address = 32'h100; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("ra_read_before", bus.read, 1);
        chk("ra_intercept_before", bus.intercept, 1);
        r0 = rspv_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("ra_intercept", bus.intercept, 0);
        chk("ra_read", bus.read, 0);
        chk("ra_write", bus.write, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        hold_avail = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ra_no_rsp", rspv_cnt, r0);
        chk("ra_ready", cmd_ready, 1);
        chk("ra_rdata_cleared", rsp_rdata, 0);

        // Two commands presented back to back with cmd_valid held high.
        @(negedge clk);
        cmd_write = 1'b1; cmd_size = 2'd2; cmd_address = 32'h108; cmd_wdata = 32'hA5A55A5A;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_write = 1'b0; cmd_wdata = 32'h0;
        rsp_it = -1;
        acc_it = -1;
        for (int j = 1; j <= 20 && acc_it < 0; j++) begin
            @(negedge clk);
            if (rsp_valid) rsp_it = j;
            if (cmd_ready) acc_it = j;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("b2b_first_rsp_cycle", rsp_it, 3);
        chk("b2b_second_accept_cycle", acc_it, 4);
        n = 1;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_second_lat", n, 3);
        chk("b2b_second_rdata", rsp_rdata, 32'hA5A55A5A);
        chk("b2b_second_err", rsp_error, 0);
        @(posedge clk); #1;
        chk("busy_ready_overlap", overlap_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
